// File: rtl/riscv_trap_pkg.sv
// Shared constants for the machine-mode trap controller: CSR addresses,
// cause codes and the controller FSM states.
package riscv_trap_pkg;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MIE     = 12'h304;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_MTVAL   = 12'h343;
   localparam logic [11:0] CSR_MIP     = 12'h344;

   localparam logic [5:0] CAUSE_INSTMIS   = 6'd0;
   localparam logic [5:0] CAUSE_ILLEGAL   = 6'd2;
   localparam logic [5:0] CAUSE_LOADMIS   = 6'd4;
   localparam logic [5:0] CAUSE_STOREMIS  = 6'd6;
   localparam logic [5:0] CAUSE_ECALL     = 6'd11;
   localparam logic [5:0] CAUSE_IRQ_TIMER = 6'd7;
   localparam logic [5:0] CAUSE_IRQ_EXT   = 6'd11;

   typedef enum logic {IDLE, BLANK} trap_state_e;

   // Only the misaligned exceptions carry a faulting address into mtval.
   function automatic logic is_misaligned(input logic [5:0] c);
      return (c == CAUSE_INSTMIS) || (c == CAUSE_LOADMIS) || (c == CAUSE_STOREMIS);
   endfunction

endpackage

// File: rtl/riscv_trap_prio.sv
// Combinational event priority encoder: interrupts, then exceptions in
// architectural order, then mret.
module riscv_trap_prio
   import riscv_trap_pkg::*;
(
   input  logic       en,
   input  logic       exc_instmis,
   input  logic       exc_illegal,
   input  logic       exc_ecall,
   input  logic       exc_loadmis,
   input  logic       exc_storemis,
   input  logic       irq_ext,
   input  logic       irq_timer,
   input  logic       mret,
   output logic       take_trap,
   output logic       take_mret,
   output logic       is_irq,
   output logic [5:0] cause
);

   always_comb begin
      take_trap = 1'b0;
      take_mret = 1'b0;
      is_irq    = 1'b0;
      cause     = '0;
      if (en) begin
         if (irq_ext) begin
            take_trap = 1'b1; is_irq = 1'b1; cause = CAUSE_IRQ_EXT;
         end else if (irq_timer) begin
            take_trap = 1'b1; is_irq = 1'b1; cause = CAUSE_IRQ_TIMER;
         end else if (exc_instmis) begin
            take_trap = 1'b1; cause = CAUSE_INSTMIS;
         end else if (exc_illegal) begin
            take_trap = 1'b1; cause = CAUSE_ILLEGAL;
         end else if (exc_ecall) begin
            take_trap = 1'b1; cause = CAUSE_ECALL;
         end else if (exc_loadmis) begin
            take_trap = 1'b1; cause = CAUSE_LOADMIS;
         end else if (exc_storemis) begin
            take_trap = 1'b1; cause = CAUSE_STOREMIS;
         end else if (mret) begin
            take_mret = 1'b1;
         end
      end
   end

endmodule

// File: rtl/riscv_trap_ctrl.sv
// Machine-mode trap controller beside WB: trap entry/mret strobes, redirect
// target and trap CSRs. Define RISCV_TRAP_VECTORED_EN for vectored interrupts.
module riscv_trap_ctrl
   import riscv_trap_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic            i_riscv_clk,
   input  logic            i_riscv_rst,
   input  logic            i_riscv_trap_valid_wb,
   input  logic [XLEN-1:0] i_riscv_trap_pc_wb,
   input  logic            i_riscv_trap_exc_instmis,
   input  logic            i_riscv_trap_exc_illegal,
   input  logic            i_riscv_trap_exc_ecall,
   input  logic            i_riscv_trap_exc_loadmis,
   input  logic            i_riscv_trap_exc_storemis,
   input  logic [XLEN-1:0] i_riscv_trap_badaddr,
   input  logic            i_riscv_trap_mret,
   input  logic            i_riscv_trap_timer_irq,
   input  logic            i_riscv_trap_ext_irq,
   input  logic            i_riscv_trap_csr_we,
   input  logic [11:0]     i_riscv_trap_csr_addr,
   input  logic [XLEN-1:0] i_riscv_trap_csr_wdata,
   output logic [XLEN-1:0] o_riscv_trap_csr_rdata,
   output logic            o_riscv_trap_gototrap,
   output logic            o_riscv_trap_returnfromtrap,
   output logic [XLEN-1:0] o_riscv_trap_target
);

   localparam logic [XLEN-1:0] EVEN_MASK = {{(XLEN-1){1'b1}}, 1'b0};

   trap_state_e     state, state_nxt;
   logic            mst_mie, mst_mpie, mie_mtie, mie_meie;
   logic [XLEN-1:0] mtvec, mepc, mcause, mtval;
   logic [XLEN-1:0] mtvec_wval, tvec_base;
   logic            ev_en, pend_ext, pend_tmr, vec_mode, csr_wr;
   logic            take_trap, take_mret, is_irq;
   logic [5:0]      cause;

   assign ev_en    = (state == IDLE) && i_riscv_trap_valid_wb;
   assign pend_ext = mst_mie & mie_meie & i_riscv_trap_ext_irq   & i_riscv_trap_valid_wb;
   assign pend_tmr = mst_mie & mie_mtie & i_riscv_trap_timer_irq & i_riscv_trap_valid_wb;

   riscv_trap_prio u_prio (
      .en           (ev_en),
      .exc_instmis  (i_riscv_trap_exc_instmis),
      .exc_illegal  (i_riscv_trap_exc_illegal),
      .exc_ecall    (i_riscv_trap_exc_ecall),
      .exc_loadmis  (i_riscv_trap_exc_loadmis),
      .exc_storemis (i_riscv_trap_exc_storemis),
      .irq_ext      (pend_ext),
      .irq_timer    (pend_tmr),
      .mret         (i_riscv_trap_mret),
      .take_trap    (take_trap),
      .take_mret    (take_mret),
      .is_irq       (is_irq),
      .cause        (cause)
   );

   // The trapping instruction never gets to write its own CSR.
   assign csr_wr    = ev_en && i_riscv_trap_csr_we && !take_trap;
   assign tvec_base = {mtvec[XLEN-1:2], 2'b00};

`ifdef RISCV_TRAP_VECTORED_EN
   assign vec_mode   = (mtvec[1:0] == 2'b01);
   assign mtvec_wval = {i_riscv_trap_csr_wdata[XLEN-1:2],
                        (i_riscv_trap_csr_wdata[1:0] == 2'b01) ? 2'b01 : 2'b00};
`else
   assign vec_mode   = 1'b0;
   assign mtvec_wval = {i_riscv_trap_csr_wdata[XLEN-1:2], 2'b00};
`endif

   always_ff @(posedge i_riscv_clk or negedge i_riscv_rst) begin
      if (!i_riscv_rst) state <= IDLE;
      else              state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (take_trap || take_mret) state_nxt = BLANK;
         BLANK:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      o_riscv_trap_gototrap       = 1'b0;
      o_riscv_trap_returnfromtrap = 1'b0;
      o_riscv_trap_target         = '0;
      if (i_riscv_rst && state == IDLE) begin
         o_riscv_trap_gototrap       = take_trap;
         o_riscv_trap_returnfromtrap = take_mret;
         if (take_trap)
            o_riscv_trap_target = (is_irq && vec_mode) ?
                                  tvec_base + XLEN'({cause, 2'b00}) : tvec_base;
         else if (take_mret)
            o_riscv_trap_target = mepc;
      end
   end

   always_ff @(posedge i_riscv_clk or negedge i_riscv_rst) begin
      if (!i_riscv_rst) begin
         mst_mie  <= 1'b0;
         mst_mpie <= 1'b0;
         mie_mtie <= 1'b0;
         mie_meie <= 1'b0;
         mtvec    <= '0;
         mepc     <= '0;
         mcause   <= '0;
         mtval    <= '0;
      end else if (take_trap) begin
         mepc     <= i_riscv_trap_pc_wb & EVEN_MASK;
         mcause   <= {is_irq, {(XLEN-7){1'b0}}, cause};
         mtval    <= (!is_irq && is_misaligned(cause)) ? i_riscv_trap_badaddr : '0;
         mst_mpie <= mst_mie;
         mst_mie  <= 1'b0;
      end else begin
         if (csr_wr) begin
            case (i_riscv_trap_csr_addr)
               CSR_MSTATUS: begin
                  mst_mie  <= i_riscv_trap_csr_wdata[3];
                  mst_mpie <= i_riscv_trap_csr_wdata[7];
               end
               CSR_MIE: begin
                  mie_mtie <= i_riscv_trap_csr_wdata[7];
                  mie_meie <= i_riscv_trap_csr_wdata[11];
               end
               CSR_MTVEC:  mtvec  <= mtvec_wval;
               CSR_MEPC:   mepc   <= i_riscv_trap_csr_wdata & EVEN_MASK;
               CSR_MCAUSE: mcause <= i_riscv_trap_csr_wdata;
               CSR_MTVAL:  mtval  <= i_riscv_trap_csr_wdata;
               default: ;
            endcase
         end
         // mret's mstatus update wins over a same-cycle mstatus write.
         if (take_mret) begin
            mst_mie  <= mst_mpie;
            mst_mpie <= 1'b1;
         end
      end
   end

   always_comb begin
      o_riscv_trap_csr_rdata = '0;
      if (i_riscv_rst) begin
         case (i_riscv_trap_csr_addr)
            CSR_MSTATUS: begin
               o_riscv_trap_csr_rdata[3] = mst_mie;
               o_riscv_trap_csr_rdata[7] = mst_mpie;
            end
            CSR_MIE: begin
               o_riscv_trap_csr_rdata[7]  = mie_mtie;
               o_riscv_trap_csr_rdata[11] = mie_meie;
            end
            CSR_MTVEC:  o_riscv_trap_csr_rdata = mtvec;
            CSR_MEPC:   o_riscv_trap_csr_rdata = mepc;
            CSR_MCAUSE: o_riscv_trap_csr_rdata = mcause;
            CSR_MTVAL:  o_riscv_trap_csr_rdata = mtval;
            CSR_MIP: begin
               o_riscv_trap_csr_rdata[7]  = i_riscv_trap_timer_irq;
               o_riscv_trap_csr_rdata[11] = i_riscv_trap_ext_irq;
            end
            default: ;
         endcase
      end
   end

endmodule
